instr_prefetch_buffer: RTL and testbench

//  Instruction fetch front end between the instruction memory port and the pipeline IF stage.
//  - Issues word-aligned fetch requests over the req/gnt/rvalid protocol.
//  - Buffers returned words with their PC in a DEPTH-entry FIFO and hands them to IF on valid/ready.
//  - On a taken branch, flushes the buffer and drops stale in-flight responses.

---
 rtl/instr_prefetch_buffer.sv | 173 +++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues word-aligned fetches and queues returned words with their PC for IF.
// Optional macro PREFETCH_BYPASS_EN: a response arriving at an empty FIFO is presented to IF combinationally.
module instr_prefetch_buffer #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en_i,
    input  logic [WORD_WIDTH-1:0] pc_start_addr_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic                  busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic [WORD_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  stale_q, stale_d;
    logic [WORD_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [WORD_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         out_q, out_d;
    logic [CW-1:0]         discard_q, discard_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [WORD_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [WORD_WIDTH-1:0] fifo_data_d [DEPTH];
    logic [WORD_WIDTH-1:0] fifo_pc_q   [DEPTH];
    logic [WORD_WIDTH-1:0] fifo_pc_d   [DEPTH];

    logic        gnt_fire, drop, push_cand, push, pop, bypass, empty;
    logic [CW:0] inflight;

    // Both handshakes transfer on a cycle where the initiator's valid (req / instr_valid_o) and the
    // responder's accept (gnt / instr_ready_i) are high together; once raised, req holds with a stable address.
    always_comb begin
        gnt_fire  = req_q && instr_gnt_i;
        drop      = instr_rvalid_i && (discard_q != '0);
        push_cand = instr_rvalid_i && (discard_q == '0) && !branch_i;
        empty     = (cnt_q == '0);
`ifdef PREFETCH_BYPASS_EN
        bypass    = empty && push_cand;
`else
        bypass    = 1'b0;
`endif
        instr_valid_o = (!empty || bypass) && !branch_i;
        instr_rdata_o = bypass ? instr_rdata_i : fifo_data_q[rd_ptr_q];
        pc_o          = bypass ? resp_pc_q : fifo_pc_q[rd_ptr_q];
        pop           = instr_valid_o && instr_ready_i && !bypass;
        push          = push_cand && !(bypass && instr_ready_i);

        instr_req_o  = req_q;
        instr_addr_o = req_addr_q;
        busy_o       = (out_q != '0) || (discard_q != '0) || req_q;

        state_d     = state_q;
        next_addr_d = next_addr_q;
        resp_pc_d   = resp_pc_q;
        stale_d     = stale_q && !gnt_fire;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        out_d = out_q + CW'(gnt_fire) - CW'(instr_rvalid_i);
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        // A stale request that finally gets granted becomes one more response to throw away.
        discard_d = discard_q;
        if (drop)
            discard_d = discard_d - CW'(1);
        if (gnt_fire && stale_q)
            discard_d = discard_d + CW'(1);

        if (gnt_fire && !stale_q)
            next_addr_d = next_addr_q + WORD_WIDTH'(4);

        if (push) begin
            fifo_data_d[wr_ptr_q] = instr_rdata_i;
            fifo_pc_d[wr_ptr_q]   = resp_pc_q;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end
        if (push_cand)
            resp_pc_d = resp_pc_q + WORD_WIDTH'(4);
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);

        case (state_q)
            IDLE: begin
                if (fetch_en_i) begin
                    state_d     = RUN;
                    next_addr_d = {pc_start_addr_i[WORD_WIDTH-1:2], 2'b00};
                    resp_pc_d   = {pc_start_addr_i[WORD_WIDTH-1:2], 2'b00};
                end
            end
            RUN: begin
                if (!fetch_en_i && !(req_q && !instr_gnt_i))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (branch_i) begin
            next_addr_d = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
            resp_pc_d   = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
            discard_d   = out_d;
            stale_d     = req_q && !instr_gnt_i;
            cnt_d       = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
        end

        // Every buffered or in-flight word reserves a FIFO slot, so a response can never overflow it.
        inflight   = {1'b0, cnt_d} + {1'b0, out_d};
        req_d      = 1'b0;
        req_addr_d = req_addr_q;
        if (req_q && !instr_gnt_i) begin
            req_d = 1'b1;
        end else if (state_d == RUN && fetch_en_i && inflight < DEPTH_C) begin
            req_d      = 1'b1;
            req_addr_d = next_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            req_addr_q  <= '0;
            stale_q     <= 1'b0;
            next_addr_q <= '0;
            resp_pc_q   <= '0;
            out_q       <= '0;
            discard_q   <= '0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_addr_q  <= req_addr_d;
            stale_q     <= stale_d;
            next_addr_q <= next_addr_d;
            resp_pc_q   <= resp_pc_d;
            out_q       <= out_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: memory model with configurable latency plus an in-order scoreboard.
module tb_instr_prefetch_buffer;
    localparam int W = 32;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT_EXP = 1;
`else
    localparam int LAT_EXP = 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fetch_en_i = 1'b0;
    logic [W-1:0] pc_start_addr_i = '0;
    logic         branch_i = 1'b0;
    logic [W-1:0] branch_addr_i = '0;
    logic         instr_req_o;
    logic [W-1:0] instr_addr_o;
    logic         instr_gnt_i = 1'b0;
    logic         instr_rvalid_i = 1'b0;
    logic [W-1:0] instr_rdata_i = '0;
    logic         instr_valid_o;
    logic         instr_ready_i = 1'b0;
    logic [W-1:0] instr_rdata_o;
    logic [W-1:0] pc_o;
    logic         busy_o;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.WORD_WIDTH(W), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .fetch_en_i(fetch_en_i), .pc_start_addr_i(pc_start_addr_i),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_rdata_o(instr_rdata_o), .pc_o(pc_o), .busy_o(busy_o)
    );

    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   mem_addr_q[$];
    int             mem_due_q[$];
    logic [W-1:0]   pop_log[$];
    int             n_checks = 0;
    int             n_errors = 0;
    int             cycle = 0;
    int             mem_lat = 1;
    int             n_gnt = 0;
    int             n_pop = 0;
    int             first_gnt_cyc = -1;
    int             first_valid_cyc = -1;
    logic [W-1:0]   next_fetch = '0;
    logic           stale = 1'b0;
    logic [W-1:0]   stale_addr = '0;
    logic           track_first = 1'b0;
    logic [W-1:0]   first_pc = '1;
    logic [W-1:0]   last_pop_pc = '0;
    logic [W-1:0]   held_addr;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, advance the memory model after the rising edge.
    task automatic tick();
        logic [2*W-1:0] e;
        @(negedge clk);
        if (instr_req_o && instr_gnt_i) begin
            n_gnt++;
            if (first_gnt_cyc < 0) first_gnt_cyc = cycle;
            mem_addr_q.push_back(instr_addr_o);
            mem_due_q.push_back(cycle + mem_lat);
        end
        if (instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cycle;
        if (branch_i) begin
            check("branch_valid_low", 64'(instr_valid_o), 64'd0);
            exp_q.delete();
            next_fetch  = {branch_addr_i[W-1:2], 2'b00};
            stale       = instr_req_o && !instr_gnt_i;
            stale_addr  = instr_addr_o;
            track_first = 1'b1;
        end else begin
            if (instr_req_o && instr_gnt_i) begin
                if (stale) begin
                    check("stale_addr", 64'(instr_addr_o), 64'(stale_addr));
                    stale = 1'b0;
                end else begin
                    check("gnt_addr", 64'(instr_addr_o), 64'(next_fetch));
                    exp_q.push_back({next_fetch, mem_word(next_fetch)});
                    next_fetch = next_fetch + 32'd4;
                end
            end
            if (instr_valid_o && instr_ready_i) begin
                n_pop++;
                last_pop_pc = pc_o;
                pop_log.push_back(pc_o);
                if (track_first) begin
                    first_pc    = pc_o;
                    track_first = 1'b0;
                end
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_pc_data", {pc_o, instr_rdata_o}, e);
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (mem_due_q.size() != 0 && mem_due_q[0] <= cycle) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_en_i = 1'b0; branch_i = 1'b0; instr_gnt_i = 1'b0; instr_ready_i = 1'b0;
        mem_addr_q.delete(); mem_due_q.delete(); exp_q.delete();
        instr_rvalid_i = 1'b0; instr_rdata_i = '0; stale = 1'b0; track_first = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_fetch(input logic [W-1:0] a);
        pc_start_addr_i = a;
        next_fetch      = {a[W-1:2], 2'b00};
        fetch_en_i      = 1'b1;
    endtask

    task automatic do_branch(input logic [W-1:0] a);
        branch_addr_i = a;
        branch_i      = 1'b1;
        tick();
        branch_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 64'(instr_valid_o), 64'd0);
        check("rst_req", 64'(instr_req_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_addr", 64'(instr_addr_o), 64'd0);
        check("rst_pc", 64'(pc_o), 64'd0);
        check("rst_rdata", 64'(instr_rdata_o), 64'd0);

        // Streaming from 0x100 with first-word latency
        mem_lat = 1; instr_gnt_i = 1'b1; instr_ready_i = 1'b1;
        first_gnt_cyc = -1; first_valid_cyc = -1;
        start_fetch(32'h100);
        repeat (12) tick();
        check("latency", 64'(first_valid_cyc - first_gnt_cyc), 64'(LAT_EXP));
        check("stream_popped", 64'(n_pop >= 8), 64'd1);

        // Back-pressure: FIFO fills with exactly four grants
        do_reset();
        instr_gnt_i = 1'b1; instr_ready_i = 1'b0; n_gnt = 0;
        start_fetch(32'h100);
        repeat (10) tick();
        check("full_grants", 64'(n_gnt), 64'd4);
        check("full_req_low", 64'(instr_req_o), 64'd0);
        check("full_valid", 64'(instr_valid_o), 64'd1);
        check("full_busy", 64'(busy_o), 64'd0);
        instr_ready_i = 1'b1; n_pop = 0;
        repeat (4) tick();
        check("drain_pops", 64'(n_pop), 64'd4);
        check("drain_last_pc", 64'(last_pop_pc), 64'h10C);

        // Branch with several responses in flight
        mem_lat = 3;
        repeat (6) tick();
        check("inflight_busy", 64'(busy_o), 64'd1);
        do_branch(32'h200);
        repeat (15) tick();
        check("br_first_pc", 64'(first_pc), 64'h200);

        // Branch while a request waits for grant
        mem_lat = 1; instr_gnt_i = 1'b0;
        for (int i = 0; i < 20 && !instr_req_o; i++) tick();
        check("req_pending", 64'(instr_req_o), 64'd1);
        held_addr = instr_addr_o;
        tick();
        check("hold_addr0", 64'(instr_addr_o), 64'(held_addr));
        first_pc = '1;
        do_branch(32'h200);
        check("hold_addr1", 64'(instr_addr_o), 64'(held_addr));
        check("hold_req1", 64'(instr_req_o), 64'd1);
        tick();
        check("hold_addr2", 64'(instr_addr_o), 64'(held_addr));
        instr_gnt_i = 1'b1;
        repeat (12) tick();
        check("stale_first_pc", 64'(first_pc), 64'h200);

        // Stop and drain
        fetch_en_i = 1'b0;
        repeat (10) tick();
        check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        check("drain_idle_busy", 64'(busy_o), 64'd0);
        check("drain_idle_valid", 64'(instr_valid_o), 64'd0);

        // Address wrap at the top of memory
        do_reset();
        mem_lat = 1; instr_gnt_i = 1'b1; instr_ready_i = 1'b1;
        pop_log.delete();
        start_fetch(32'hFFFF_FFF8);
        repeat (10) tick();
        check("wrap_count", 64'(pop_log.size() >= 3), 64'd1);
        if (pop_log.size() >= 3) begin
            check("wrap_pc0", 64'(pop_log[0]), 64'hFFFF_FFF8);
            check("wrap_pc1", 64'(pop_log[1]), 64'hFFFF_FFFC);
            check("wrap_pc2", 64'(pop_log[2]), 64'h0);
        end

        // Reset mid-operation with a partly filled FIFO
        instr_ready_i = 1'b0;
        repeat (2) tick();
        check("pre_rst_valid", 64'(instr_valid_o), 64'd1);
        do_reset();
        check("mid_rst_valid", 64'(instr_valid_o), 64'd0);
        check("mid_rst_req", 64'(instr_req_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        repeat (2) tick();
        check("idle_req", 64'(instr_req_o), 64'd0);
        check("idle_valid", 64'(instr_valid_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
